// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks:
//   - rx_state_e       : receiver FSM state encoding
//   - DATA_BITS        : data bits per frame (8N1, LSB first)
//   - EXTRA_STOP_BITS  : idle-high bits the transmitter appends after each stop bit
//   - timer_width()    : width of a bit-timer counting 0 .. clocks_per_bit-1
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS       = 8;
    localparam int EXTRA_STOP_BITS = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Bits needed to hold clocks_per_bit-1; never less than one bit.
    function automatic int timer_width(input int clocks_per_bit);
        int w;
        w = $clog2(clocks_per_bit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the idle-high serial line. Both flops reset to 1
// so the receiver never sees a false start bit coming out of reset.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   d_i    in   asynchronous input
//   q_o    out  synchronized output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver, LSB first. Samples each bit at its centre using a
// down-counting bit timer started from the falling edge of the start bit.
// Good bytes produce a one-cycle rx_valid pulse and are added to a wrapping
// 32-bit checksum; a low stop bit produces a one-cycle rx_error pulse and the
// receiver then waits for the line to return high so a break is not decoded
// as a stream of 0x00 frames.
//
// Parameter:
//   clocks_per_bit  clk cycles per serial bit (>= 2, must match transmitter)
// Ports:
//   clk       in   clock, all state on posedge
//   rst_n     in   asynchronous active-low reset
//   SER_RX    in   serial line, idle high
//   rx_data   out  [7:0]  last good byte, held until the next good frame
//   rx_valid  out  one-cycle pulse, rx_data is new this cycle
//   rx_error  out  one-cycle pulse, framing error (stop bit sampled low)
//   rx_sum    out  [31:0] wrapping sum of all good bytes since reset
//
// Build option: define UART_RX_SYNC_EN to pass SER_RX through a 2-flop
// synchronizer (uart_sync2) first; every sample point then moves 2 cycles
// later. Without it SER_RX feeds the FSM directly (same-clock loopback).
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SER_RX,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_error,
    output logic [31:0] rx_sum
);

    localparam int TW       = timer_width(clocks_per_bit);
    localparam int HALF_BIT = clocks_per_bit / 2;
    localparam int CW       = $clog2(DATA_BITS);

    // Start-bit centre is half_bit cycles after the falling edge; the timer
    // is loaded with one less because the load cycle itself counts.
    localparam logic [TW-1:0] HALF_M1   = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_M1    = TW'(clocks_per_bit - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);

    logic rx_in;

`ifdef UART_RX_SYNC_EN
    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (SER_RX),
        .q_o   (rx_in)
    );
`else
    assign rx_in = SER_RX;
`endif

    rx_state_e        state_q;
    logic [TW-1:0]    timer_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             rx_error_q;
    logic [31:0]      rx_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            rx_sum_q   <= '0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_in) begin
                        state_q <= START;
                        timer_q <= HALF_M1;
                    end
                end

                START: begin
                    if (timer_q == '0) begin
                        if (rx_in) begin
                            // Line back high at the start-bit centre: glitch.
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            timer_q   <= BIT_M1;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                DATA: begin
                    if (timer_q == '0) begin
                        // LSB arrives first, so shift in from the top.
                        shift_q   <= {rx_in, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        timer_q   <= BIT_M1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                STOP: begin
                    if (timer_q == '0) begin
                        if (rx_in) begin
                            // Back to IDLE now so a start bit arriving in
                            // the rx_valid cycle is still caught.
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            rx_sum_q   <= rx_sum_q + {24'd0, shift_q};
                            state_q    <= IDLE;
                        end else begin
                            rx_error_q <= 1'b1;
                            state_q    <= WAIT_HIGH;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end

                WAIT_HIGH: begin
                    if (rx_in) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;
    assign rx_sum   = rx_sum_q;

endmodule
